// File: rtl/if_fetch_buffer.sv
// Fetch-to-decode FIFO of {pc, instr} pairs with valid/ready handshake and flush.
// Optional zero-latency empty bypass: define IF_FETCH_BUFFER_BYPASS_EN.
module if_fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_pc_plus1,
    output logic [31:0]                out_instr,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          full;
    logic          empty;
    logic          byp_take;
    logic          push;
    logic          pop;
    logic [31:0]   sel_instr;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;

`ifdef IF_FETCH_BUFFER_BYPASS_EN
    logic byp;
    // An empty buffer forwards the incoming entry; it is only stored if decode stalls.
    assign byp       = empty && in_valid && !flush;
    assign byp_take  = byp && out_ready;
    assign out_valid = !empty || byp;
    assign out_pc    = byp ? in_pc    : mem[rp][63:32];
    assign sel_instr = byp ? in_instr : mem[rp][31:0];
`else
    assign byp_take  = 1'b0;
    assign out_valid = !empty;
    assign out_pc    = mem[rp][63:32];
    assign sel_instr = mem[rp][31:0];
`endif

    assign out_instr    = out_valid ? sel_instr : '0;
    assign out_pc_plus1 = out_pc + 32'd1;

    assign push = in_valid && in_ready && !flush && !byp_take;
    assign pop  = !empty && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop)  rp <= rp + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wp] <= {in_pc, in_instr};
    end
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer: queue-based reference model checked every cycle
// plus literal expectations for the fill/drain, stream, flush, wrap and reset scenarios.
module tb_if_fetch_buffer;
    localparam int DEPTH = 4;
`ifdef IF_FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus1;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  count;

    if_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_pc_plus1(out_pc_plus1), .out_instr(out_instr), .out_ready(out_ready),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] q[$];      // model contents, front = oldest
    logic [31:0] popped[$]; // pcs decode actually consumed
    bit          model_ok = 1'b0;

    logic        s_valid, s_ready;
    logic [31:0] s_pc, s_plus1, s_instr;
    logic [2:0]  s_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, sample and compare against the model, then advance the model.
    task automatic cycle(input bit iv, input logic [31:0] ipc, input logic [31:0] iin,
                         input bit ordy, input bit fl, input bit rs);
        bit          e_valid;
        logic [31:0] e_pc, e_instr;
        bit          byp, pop_m, push_m;
        @(negedge clk);
        in_valid = iv; in_pc = ipc; in_instr = iin; out_ready = ordy; flush = fl; rst = rs;
        #1;
        s_valid = out_valid; s_ready = in_ready; s_pc = out_pc; s_plus1 = out_pc_plus1;
        s_instr = out_instr; s_count = count;
        byp = BYP && q.size() == 0 && iv && !fl;
        if (q.size() > 0) begin
            e_valid = 1'b1; e_pc = q[0][63:32]; e_instr = q[0][31:0];
        end else if (byp) begin
            e_valid = 1'b1; e_pc = ipc; e_instr = iin;
        end else begin
            e_valid = 1'b0; e_pc = '0; e_instr = '0;
        end
        if (model_ok) begin
            chk("m_out_valid", {31'd0, s_valid}, {31'd0, e_valid});
            chk("m_out_instr", s_instr, e_instr);
            chk("m_count", {29'd0, s_count}, 32'(q.size()));
            chk("m_in_ready", {31'd0, s_ready}, {31'd0, q.size() < DEPTH});
            if (e_valid) begin
                chk("m_out_pc", s_pc, e_pc);
                chk("m_out_pc_plus1", s_plus1, e_pc + 32'd1);
            end
        end
        if (s_valid && ordy && !fl && !rs) popped.push_back(s_pc);
        @(posedge clk);
        if (rs || fl) begin
            q.delete();
        end else begin
            pop_m  = q.size() > 0 && ordy;
            push_m = iv && q.size() < DEPTH && !(byp && ordy);
            if (pop_m)  void'(q.pop_front());
            if (push_m) q.push_back({ipc, iin});
        end
        if (rs) model_ok = 1'b1;
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, '0, '0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        chk("reset_count", {29'd0, s_count}, 32'd0);
        chk("reset_in_ready", {31'd0, s_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, s_valid}, 32'd0);
        chk("reset_out_instr", s_instr, 32'd0);

        // Fill to full, then offer a fifth entry
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'(i), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
            chk("fill_count", {29'd0, s_count}, 32'(i));
        end
        cycle(1'b1, 32'd4, 32'hA4, 1'b0, 1'b0, 1'b0);
        chk("full_count", {29'd0, s_count}, 32'd4);
        chk("full_in_ready", {31'd0, s_ready}, 32'd0);
        idle(1'b0);
        chk("full_hold_count", {29'd0, s_count}, 32'd4);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("drain_pc", s_pc, 32'(i));
            chk("drain_plus1", s_plus1, 32'(i + 1));
            chk("drain_instr", s_instr, 32'hA0 + 32'(i));
        end
        idle(1'b0);
        chk("drained_valid", {31'd0, s_valid}, 32'd0);
        chk("drained_instr", s_instr, 32'd0);

        // Continuous stream, pointers wrap
        popped.delete();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'd10 + 32'(i), 32'hB00 + 32'(i), 1'b1, 1'b0, 1'b0);
            if (i > 0) chk("stream_count", {29'd0, s_count}, BYP ? 32'd0 : 32'd1);
        end
        idle(1'b1);
        idle(1'b1);
        chk("stream_n", 32'(popped.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            if (i < popped.size()) chk("stream_order", popped[i], 32'd10 + 32'(i));

        // Flush with simultaneous push and pop
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'd30 + 32'(i), 32'hC0 + 32'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'd33, 32'hC3, 1'b1, 1'b1, 1'b0);
        chk("preflush_count", {29'd0, s_count}, 32'd3);
        idle(1'b0);
        chk("flush_count", {29'd0, s_count}, 32'd0);
        chk("flush_valid", {31'd0, s_valid}, 32'd0);
        cycle(1'b1, 32'd40, 32'hD0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        chk("postflush_pc", s_pc, 32'd40);
        chk("postflush_valid", {31'd0, s_valid}, 32'd1);
        idle(1'b0);

        // PC wrap for the link value
        cycle(1'b1, 32'hFFFF_FFFF, 32'hE0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        chk("wrap_pc", s_pc, 32'hFFFF_FFFF);
        chk("wrap_plus1", s_plus1, 32'd0);
        idle(1'b0);

        // Reset mid-operation during a push
        cycle(1'b1, 32'd50, 32'hF0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'd51, 32'hF1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'd52, 32'hF2, 1'b0, 1'b0, 1'b1);
        chk("prerst_count", {29'd0, s_count}, 32'd2);
        idle(1'b0);
        chk("rst_count", {29'd0, s_count}, 32'd0);
        chk("rst_in_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_valid", {31'd0, s_valid}, 32'd0);

        // Empty with input and decode ready
        cycle(1'b1, 32'd7, 32'h77, 1'b1, 1'b0, 1'b0);
        chk("empty_take_valid", {31'd0, s_valid}, {31'd0, BYP});
        idle(1'b0);
        chk("empty_take_count", {29'd0, s_count}, BYP ? 32'd0 : 32'd1);
        idle(1'b1);
        idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/if_fetch_buffer.md
# if_fetch_buffer

- Instruction fetch buffer between the program counter/instruction memory and the decode stage of the 32-bit MIPS core.
- Captures each fetched {pc, instruction} pair into a small FIFO and presents it to decode with a valid/ready handshake.
- Decouples decode stalls from fetch and discards wrong-path instructions on a branch/jump redirect.
- PC values are word addresses; the sequential successor is pc+1.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  fetch side presents a valid {in_pc, in_instr}.
- in_pc  input  32  word address of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- in_ready  output  1  buffer accepts this cycle; = !full. Fetch uses !in_ready as its PC hold.
- out_valid  output  1  an instruction is presented to decode.
- out_pc  output  32  word address of presented instruction.
- out_pc_plus1  output  32  out_pc + 1, modulo 2^32; link value for jal.
- out_instr  output  32  presented instruction; forced to 32'h0000_0000 (NOP) when out_valid=0.
- out_ready  input  1  decode consumes the presented entry this cycle.
- flush  input  1  redirect; discard all buffered and incoming entries.
- count  output  clog2(DEPTH+1)  current occupancy.

## Operation
- Storage: DEPTH×64-bit entries {pc, instr}, write pointer wp, read pointer rp, each clog2(DEPTH) bits, wrapping modulo DEPTH; count tracks occupancy 0..DEPTH.
- push = in_valid && in_ready && !flush; writes entry[wp], wp+1.
- pop = out_valid && out_ready && !flush; rp+1.
- Occupancy update: push && !pop: count+1. pop && !push: count−1. Both or neither: unchanged.
- Simultaneous push and pop with 0<count<DEPTH: both take effect, count unchanged.
- full (count==DEPTH): in_ready=0, in_valid ignored, no overwrite; a pop in that cycle frees one slot, visible as in_ready=1 in the next cycle only (no same-cycle pass-through).
- empty (count==0): out_valid=0 (except bypass, see Configuration); out_ready ignored; no underflow.
- out_valid = (count!=0); out_pc/out_instr = entry[rp]; out_pc_plus1 = out_pc+1, so 32'hFFFF_FFFF yields 0.
- flush has priority over push and pop:
  - At the edge: count=0, wp=rp=0.
  - The in_valid entry of that cycle is dropped.
  - Decode must not treat the presented entry as consumed.
  - Entry storage contents are not cleared.
- Entry contents never need reset; only pointers and count do.

## Timing
- Reset (rst=1 at an edge): count=0, wp=0, rp=0. Hence out_valid=0, out_instr=0, out_pc=entry[0] (don't-care, must not be X-sensitive downstream), in_ready=1.
- rst has priority over flush; rst mid-operation discards all entries exactly as flush.
- Latency (non-bypass): entry pushed at edge N is visible on out_* from edge N onward, i.e. out_valid first high in cycle N+1; throughput one instruction/cycle when decode is ready.
- Ordering strictly FIFO; no reordering or duplication.
- All outputs except out_* in bypass mode are register-derived.

## Configuration
- IF_FETCH_BUFFER_BYPASS_EN defined: when count==0 and in_valid and !flush, out_valid=1 and out_* are driven combinationally from in_*.
  - If out_ready is also 1, the entry is consumed without being written: no push, count stays 0, zero-cycle latency.
  - If out_ready=0, the entry is pushed normally.
- IF_FETCH_BUFFER_BYPASS_EN undefined: no input-to-output combinational path; minimum latency one cycle as in Timing.

## Test plan
- Reset then in_valid with pcs 0..3, instrs A0..A3, out_ready=0 → count 1,2,3,4; in_ready=0 after 4th; 5th offered (pc 4) not accepted; count stays 4.
- From full, out_ready=1 for 4 cycles, in_valid=0 → out_pc 0,1,2,3 in order, out_pc_plus1 1,2,3,4; then out_valid=0, out_instr=0.
- Continuous in_valid and out_ready, pcs 10..19 → steady count=1 (0 with bypass), every pc appears exactly once in order; wp/rp wrap with no loss.
- count=3, flush=1 with in_valid=1 and out_ready=1 same cycle → next cycle count=0, out_valid=0; subsequent pc 40 is the next output.
- in_pc=32'hFFFF_FFFF pushed → out_pc_plus1=0.
- rst asserted with count=2 during push → count=0, in_ready=1, out_valid=0 next cycle.
- Bypass build, empty, in_valid+out_ready with pc 7 → out_valid=1, out_pc=7 same cycle, count stays 0.
